// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit: mult/multu/div/divu into HI/LO with a busy flag, single-cycle mthi/mtlo.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   tmp_q, tmp_d;
  logic          wr_q, wr_d;     // commit tmp at completion; cleared for divide by zero
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
`ifdef MDU_MADD_EN
  logic          acc_q, acc_d, sub_q, sub_d;
`endif

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] q_s, r_s, q_u, r_u;

  assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uprod = {32'b0, A} * {32'b0, B};

  // The overflow quotient is pinned explicitly so it does not depend on tool semantics.
  always_comb begin
    q_s = 32'h0;
    r_s = 32'h0;
    q_u = 32'h0;
    r_u = 32'h0;
    if (B != 32'h0) begin
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
        q_s = 32'h8000_0000;
        r_s = 32'h0;
      end else begin
        q_s = $signed(A) / $signed(B);
        r_s = $signed(A) % $signed(B);
      end
      q_u = A / B;
      r_u = A % B;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (MDop)
            4'd0, 4'd1: begin
              tmp_d   = (MDop == 4'd0) ? sprod : uprod;
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
`ifdef MDU_MADD_EN
              acc_d   = 1'b0;
`endif
            end
            4'd2, 4'd3: begin
              tmp_d   = (MDop == 4'd2) ? {r_s, q_s} : {r_u, q_u};
              wr_d    = (B != 32'h0);
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
`ifdef MDU_MADD_EN
              acc_d   = 1'b0;
`endif
            end
            4'd4: hi_d = A;
            4'd5: lo_d = A;
`ifdef MDU_MADD_EN
            // 6/8 signed, 7/9 unsigned; 8/9 subtract.
            4'd6, 4'd7, 4'd8, 4'd9: begin
              tmp_d   = MDop[0] ? uprod : sprod;
              wr_d    = 1'b1;
              acc_d   = 1'b1;
              sub_d   = MDop[3];
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (wr_q) begin
`ifdef MDU_MADD_EN
            if (acc_q)
              {hi_d, lo_d} = sub_q ? ({hi_q, lo_q} - tmp_q) : ({hi_q, lo_q} + tmp_q);
            else
              {hi_d, lo_d} = tmp_q;
`else
            {hi_d, lo_d} = tmp_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmp_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic HI/LO reference model.
module tb_mul_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  MDop = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDop(MDop), .start(start),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return MC;
      4'd2, 4'd3: return DC;
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      4'd0: {hi_m, lo_m} = 64'(sa * sb);
      4'd1: {hi_m, lo_m} = 64'(ua * ub);
      4'd2: if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      4'd3: if (b != 0) begin lo_m = 32'(ua / ub); hi_m = 32'(ua % ub); end
      4'd4: hi_m = a;
      4'd5: lo_m = a;
`ifdef MDU_MADD_EN
      4'd6: {hi_m, lo_m} = {hi_m, lo_m} + 64'(sa * sb);
      4'd7: {hi_m, lo_m} = {hi_m, lo_m} + 64'(ua * ub);
      4'd8: {hi_m, lo_m} = {hi_m, lo_m} - 64'(sa * sb);
      4'd9: {hi_m, lo_m} = {hi_m, lo_m} - 64'(ua * ub);
`endif
      default: ;
    endcase
  endtask

  // now=1 issues on the current negedge (first busy-low cycle of the previous op).
  // poke=1 keeps start high with a div request on every busy cycle; it must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke, input bit now);
    int n;
    if (!now) @(negedge clk);
    A = a; B = b; MDop = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; MDop = 4'($urandom);
    n = 0;
    while (busy && n < 200) begin
      n++;
      start = poke;
      A = 32'd100; B = 32'd7; MDop = 4'd2;
      @(negedge clk);
    end
    start = 1'b0;
    model(op, a, b);
    chk({tag, ".cyc"}, 64'(n), 64'(lat(op)));
    chk({tag, ".hi"}, 64'(HI), 64'(hi_m));
    chk({tag, ".lo"}, 64'(LO), 64'(lo_m));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.hi", 64'(HI), 64'd0);
    chk("rst.lo", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in the middle of a multiply.
    run_op("pre_hi", 4'd4, 32'hAAAA, 32'h0, 1'b0, 1'b0);
    run_op("pre_lo", 4'd5, 32'h5555, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    A = 32'd3; B = 32'd4; MDop = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.hi", 64'(HI), 64'd0);
    chk("arst.lo", 64'(LO), 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("arst.late_busy", 64'(busy), 64'd0);
    chk("arst.late_hi", 64'(HI), 64'd0);
    chk("arst.late_lo", 64'(LO), 64'd0);

    // Directed cases.
    run_op("mult", 4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_op("multu", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("multu.hi_k", 64'(HI), 64'h1);
    run_op("div", 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div.lo_k", 64'(LO), 64'hFFFF_FFFD);
    chk("div.hi_k", 64'(HI), 64'hFFFF_FFFF);
    run_op("divu", 4'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    run_op("mthi", 4'd4, 32'h1234, 32'h0, 1'b0, 1'b0);
    run_op("mtlo", 4'd5, 32'h5678, 32'h0, 1'b0, 1'b0);
    run_op("div0", 4'd2, 32'd99, 32'd0, 1'b0, 1'b0);
    chk("div0.hi_k", 64'(HI), 64'h1234);
    chk("div0.lo_k", 64'(LO), 64'h5678);
    run_op("divovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("divovf.lo_k", 64'(LO), 64'h8000_0000);
    chk("divovf.hi_k", 64'(HI), 64'h0);
    run_op("ignore", 4'd0, 32'd2, 32'd3, 1'b1, 1'b0);
    chk("ignore.lo_k", 64'(LO), 64'd6);
    run_op("b2b", 4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    run_op("undef", 4'd12, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
    run_op("m_hi0", 4'd4, 32'h0, 32'h0, 1'b0, 1'b0);
    run_op("m_lo", 4'd5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    run_op("maddu", 4'd7, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("maddu.hi_k", 64'(HI), 64'h1);
    chk("maddu.lo_k", 64'(LO), 64'h0);
    run_op("msub", 4'd8, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("msub.lo_k", 64'(LO), 64'hFFFF_FFFE);
`endif

    // Randomized sequence with occasional busy-time pokes and back-to-back issue.
    for (int i = 0; i < 80; i++) begin
      run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), pick(), pick(),
             bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
